// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//    ID/EX pipeline register for a classic five-stage pipeline.
//    - Forwards a same-cycle write-back value into the register-file read
//      operands, because the register file is read before it is written.
//    - Detects a load in EX whose destination is a source of the instruction
//      in ID. On that load-use hazard it inserts one bubble and asks the PC
//      and IF/ID register to hold.
//    - Counts the inserted bubbles in a saturating 16-bit counter.
//
// Ports:
//    clk, rst                  rising-edge clock, asynchronous active-high reset
//    id_valid                  ID holds a real instruction
//    id_pc4, id_imm            PC+4 and sign-extended immediate from ID
//    id_rs, id_rt, id_rd       register numbers from ID
//    id_ctrl                   decoded control bundle (CTRL_W bits)
//    id_data1, id_data2        register-file read data for rs / rt
//    wb_we, wb_reg, wb_data    write-back port (same as register-file write)
//    flush                     taken branch/jump, discard the ID instruction
//    hold                      downstream busy, freeze the EX register
//    ex_*                      registered EX-stage copies of the id_* fields
//    stall_out                 combinational hold request to PC and IF/ID
//    bubble_cnt                saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int CTRL_W      = 12,
   parameter int MEMREAD_BIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [31:0]       id_pc4,
   input  logic [31:0]       id_imm,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [31:0]       id_data1,
   input  logic [31:0]       id_data2,
   input  logic              wb_we,
   input  logic [4:0]        wb_reg,
   input  logic [31:0]       wb_data,
   input  logic              flush,
   input  logic              hold,
   output logic              ex_valid,
   output logic [31:0]       ex_pc4,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_data1,
   output logic [31:0]       ex_data2,
   output logic              stall_out,
   output logic [15:0]       bubble_cnt
);

   logic              r_exValid;
   logic [31:0]       r_exPc4;
   logic [31:0]       r_exImm;
   logic [4:0]        r_exRs;
   logic [4:0]        r_exRt;
   logic [4:0]        r_exRd;
   logic [CTRL_W-1:0] r_exCtrl;
   logic [31:0]       r_exData1;
   logic [31:0]       r_exData2;
   logic [15:0]       r_bubbleCnt;

   logic              w_bypass1;
   logic              w_bypass2;
   logic [31:0]       w_op1;
   logic [31:0]       w_op2;
   logic              w_hz;
   logic              w_doBubble;
   logic [15:0]       w_bubbleNext;

   // Write-back bypass. Register 0 is hard-wired to zero, so a write-back
   // aimed at it must never replace the register-file value.
   assign w_bypass1 = wb_we && (wb_reg != 5'd0) && (wb_reg == id_rs);
   assign w_bypass2 = wb_we && (wb_reg != 5'd0) && (wb_reg == id_rt);
   assign w_op1     = w_bypass1 ? wb_data : id_data1;
   assign w_op2     = w_bypass2 ? wb_data : id_data2;

   // Load-use hazard: the load result is not available until after MEM, so
   // the dependent instruction in ID has to wait one cycle. An empty ID slot
   // or an empty EX slot can never create a hazard.
   assign w_hz = id_valid && r_exValid && r_exCtrl[MEMREAD_BIT] &&
                 (r_exRt != 5'd0) &&
                 ((r_exRt == id_rs) || (r_exRt == id_rt));

   // A flush discards the ID instruction, so there is nothing left to stall.
   assign stall_out = !flush && (hold || w_hz);

   // A bubble is only really inserted when neither flush nor hold wins.
   assign w_doBubble   = !flush && !hold && w_hz;
   assign w_bubbleNext = (w_doBubble && (r_bubbleCnt != 16'hFFFF)) ?
                         (r_bubbleCnt + 16'd1) : r_bubbleCnt;

   // Bubble counter. It is rewritten with its next value on every edge, so
   // the count is always whatever the previous cycle decided, never stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubbleCnt <= 16'd0;
      end else begin
         r_bubbleCnt <= w_bubbleNext;
      end
   end

   // EX register update. Priority is flush, then hold, then bubble, then a
   // normal load. A bubble only kills valid/ctrl and leaves the data fields
   // as they were, since nothing downstream looks at them when invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exValid <= 1'b0;
         r_exPc4   <= 32'd0;
         r_exImm   <= 32'd0;
         r_exRs    <= 5'd0;
         r_exRt    <= 5'd0;
         r_exRd    <= 5'd0;
         r_exCtrl  <= '0;
         r_exData1 <= 32'd0;
         r_exData2 <= 32'd0;
      end else if (flush) begin
         r_exValid <= 1'b0;
         r_exPc4   <= 32'd0;
         r_exImm   <= 32'd0;
         r_exRs    <= 5'd0;
         r_exRt    <= 5'd0;
         r_exRd    <= 5'd0;
         r_exCtrl  <= '0;
         r_exData1 <= 32'd0;
         r_exData2 <= 32'd0;
      end else if (hold) begin
         r_exValid <= r_exValid;
      end else if (w_hz) begin
         r_exValid <= 1'b0;
         r_exCtrl  <= '0;
      end else begin
         r_exValid <= id_valid;
         r_exPc4   <= id_pc4;
         r_exImm   <= id_imm;
         r_exRs    <= id_rs;
         r_exRt    <= id_rt;
         r_exRd    <= id_rd;
         r_exCtrl  <= id_valid ? id_ctrl : '0;
         r_exData1 <= w_op1;
         r_exData2 <= w_op2;
      end
   end

   assign ex_valid   = r_exValid;
   assign ex_pc4     = r_exPc4;
   assign ex_imm     = r_exImm;
   assign ex_rs      = r_exRs;
   assign ex_rt      = r_exRt;
   assign ex_rd      = r_exRd;
   assign ex_ctrl    = r_exCtrl;
   assign ex_data1   = r_exData1;
   assign ex_data2   = r_exData2;
   assign bubble_cnt = r_bubbleCnt;

endmodule
